matrix_decompiler: RTL
======================

MATRIX_DECOMPILER -- requirements
Module: matrix_decompiler

Interface
REQ-001 SHALL have parameter N_ROWS, default 32, meaning matrix rows per frame.
REQ-002 SHALL have parameter N_COLS, default 32, meaning matrix columns per frame.
REQ-003 SHALL have parameter MIN_PREAMBLE, default 8, meaning the minimum number of consecutive 01 dibits before the SFD.
REQ-004 SHALL have port eth_refclk, input, 1 bit: the 50 MHz RMII reference clock and the only clock.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port crsdv, input, 1 bit: RMII carrier-sense/data-valid.
REQ-007 SHALL have port rxd, input, 2 bits: RMII receive dibit.
REQ-008 SHALL have port valid_data_out, output, 1 bit: one-cycle strobe qualifying the element and its address.
REQ-009 SHALL have port row_addr, output, $clog2(N_ROWS) bits: row of the current element.
REQ-010 SHALL have port col_addr, output, $clog2(N_COLS) bits: column of the current element.
REQ-011 SHALL have port matrix_element, output, 8 bits: the received byte.
REQ-012 SHALL have port frame_done, output, 1 bit: one-cycle pulse after the last element of a frame.
REQ-013 SHALL have port frame_error, output, 1 bit: one-cycle pulse when a frame is aborted.

Function
REQ-014 SHALL sample crsdv and rxd on the rising edge of eth_refclk; a dibit is accepted only when crsdv=1.
REQ-015 SHALL implement FSM states IDLE, PREAMBLE, PAYLOAD and DRAIN.
REQ-016 IDLE: an accepted dibit 01 SHALL set the preamble count to 1 and go to PREAMBLE; any other input SHALL leave the FSM in IDLE.
REQ-017 PREAMBLE: dibit 01 SHALL increment the count, saturating at MIN_PREAMBLE.
REQ-018 PREAMBLE: dibit 11 with count>=MIN_PREAMBLE SHALL go to PAYLOAD.
REQ-019 PREAMBLE: dibit 11 with too short a preamble, or dibit 00/10, SHALL go to DRAIN with no error pulse.
REQ-020 PREAMBLE: crsdv=0 SHALL return the FSM to IDLE.
REQ-021 PAYLOAD SHALL assemble bytes LSB-first: the first dibit goes to bits[1:0] and the fourth to bits[7:6].
REQ-022 On the 4th accepted dibit, the SHALL drive matrix_element with the byte and pulse valid_data_out for exactly one cycle in the next cycle (latency 1 clock).
REQ-023 Element order SHALL be row-major: col_addr increments per element; on col_addr=N_COLS-1 it wraps to 0 and row_addr increments.
REQ-024 The first element of each frame SHALL be (0,0).
REQ-025 On emission of element (N_ROWS-1, N_COLS-1), frame_done SHALL pulse in the same cycle as that valid_data_out and the FSM SHALL go to DRAIN.
REQ-026 Trailing bytes (FCS etc.) SHALL be ignored in DRAIN.
REQ-027 crsdv=0 in PAYLOAD before the last element SHALL pulse frame_error next cycle, discard any partial byte, and return to IDLE.
REQ-028 If crsdv=0 coincides with the 4th dibit, the frame SHALL be treated as aborted: the dibit is not accepted.
REQ-029 DRAIN SHALL wait for crsdv=0 and then go to IDLE; no outputs pulse in DRAIN.
REQ-030 Gap cycles (crsdv=1 and dibit not accepted) SHALL NOT occur in RMII 100 Mb/s mode; the block SHALL make no provision for them.
REQ-031 row_addr, col_addr and matrix_element SHALL hold their last values when valid_data_out=0.

Reset
REQ-032 While rst_n=0 at a clock edge, the FSM SHALL go to IDLE.
REQ-033 Reset SHALL clear the dibit counter, the preamble counter, row_addr, col_addr and matrix_element to 0.
REQ-034 Reset SHALL drive valid_data_out, frame_done and frame_error to 0.
REQ-035 Reset mid-frame SHALL abort the frame with no error pulse.
REQ-036 After reset release, the block SHALL resynchronise only on a fresh preamble.

Structure
REQ-037 The shared package matrix_pkg SHALL hold N_ROWS/N_COLS defaults, PREAMBLE_DIBIT=2'b01, SFD_LAST_DIBIT=2'b11 and the state enum typedef.
REQ-038 The shared package SHALL be the same one used by matrix_compiler so that transmit and receive agree.
REQ-039 One sub-module, rmii_byte_assembler (dibit to byte, LSB-first, with byte strobe and clear), SHALL be used; the FSM and address counters live in the top module.

Verification
REQ-040 Scenario: 8x01, 11, then 1024 bytes with the identity pattern (0xAA at i==j, else 0xF0) -> 1024 strobes in row-major order, 0xAA exactly at row==col, and frame_done coincident with the (31,31) strobe.
REQ-041 Scenario: byte 0x1B sent as dibits 11,10,01,00 -> matrix_element=0x1B one cycle after the 4th dibit.
REQ-042 Scenario: crsdv drops after 500 bytes plus 2 dibits -> 500 strobes, one frame_error pulse, no frame_done; the next full frame starts at (0,0).
REQ-043 Scenario: 5x01 then 11 -> DRAIN, no strobes, no error pulse.
REQ-044 Scenario: rst_n=0 for 1 cycle at element 300 -> all outputs 0; the next frame is received complete from (0,0).
REQ-045 Scenario: loopback of matrix_compiler dibit/valid into crsdv/rxd -> received matrix equals the transmitted matrix.

Source files
------------

// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared matrix framing constants and receive state type
package matrix_pkg;

    localparam int N_ROWS_DEF = 32;
    localparam int N_COLS_DEF = 32;

    localparam logic [1:0] PREAMBLE_DIBIT = 2'b01;
    localparam logic [1:0] SFD_LAST_DIBIT = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        PAYLOAD,
        DRAIN
    } matrix_state_t;

endpackage

// File: rtl/rmii_byte_assembler.sv
// rtl/rmii_byte_assembler.sv - RMII dibit to byte assembler, LSB-first, with clear
module rmii_byte_assembler (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       dibit_tvalid,
    input  logic [1:0] dibit_tdata,
    output logic       byte_tvalid,
    output logic [7:0] byte_tdata
);

    logic [1:0] dibit_cnt;
    logic [5:0] low_bits;

    // The byte is presented combinationally on the 4th dibit so the caller can register it.
    assign byte_tvalid = dibit_tvalid && (dibit_cnt == 2'd3);
    assign byte_tdata  = {dibit_tdata, low_bits};

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            dibit_cnt <= 2'd0;
            low_bits  <= 6'd0;
        end else if (dibit_tvalid) begin
            dibit_cnt <= dibit_cnt + 2'd1;
            low_bits  <= {dibit_tdata, low_bits[5:2]};
        end
    end

endmodule

// File: rtl/matrix_decompiler.sv
// rtl/matrix_decompiler.sv - RMII frame receiver emitting matrix elements in row-major order
module matrix_decompiler
    import matrix_pkg::*;
#(
    parameter int N_ROWS       = N_ROWS_DEF,
    parameter int N_COLS       = N_COLS_DEF,
    parameter int MIN_PREAMBLE = 8
) (
    input  logic                      eth_refclk,
    input  logic                      rst_n,
    input  logic                      crsdv,
    input  logic [1:0]                rxd,
    output logic                      valid_data_out,
    output logic [$clog2(N_ROWS)-1:0] row_addr,
    output logic [$clog2(N_COLS)-1:0] col_addr,
    output logic [7:0]                matrix_element,
    output logic                      frame_done,
    output logic                      frame_error
);

    localparam int RW = $clog2(N_ROWS);
    localparam int CW = $clog2(N_COLS);
    localparam int PW = $clog2(MIN_PREAMBLE + 1);

    localparam logic [RW-1:0] LAST_ROW = RW'(N_ROWS - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(N_COLS - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [PW-1:0] PRE_MIN  = PW'(MIN_PREAMBLE);
    localparam logic [PW-1:0] PRE_ONE  = PW'(1);

    matrix_state_t state;
    logic [PW-1:0] pre_cnt;
    logic [RW-1:0] row_cnt;
    logic [CW-1:0] col_cnt;
    logic          in_payload;
    logic          byte_tvalid;
    logic [7:0]    byte_tdata;

    assign in_payload = (state == PAYLOAD);

    // Held in clear outside PAYLOAD, so every frame and every abort starts on a byte boundary.
    rmii_byte_assembler u_byte_assembler (
        .clk          (eth_refclk),
        .rst_n        (rst_n),
        .clear        (!in_payload),
        .dibit_tvalid (in_payload && crsdv),
        .dibit_tdata  (rxd),
        .byte_tvalid  (byte_tvalid),
        .byte_tdata   (byte_tdata)
    );

    always_ff @(posedge eth_refclk) begin
        if (!rst_n) begin
            state          <= IDLE;
            pre_cnt        <= '0;
            row_cnt        <= '0;
            col_cnt        <= '0;
            row_addr       <= '0;
            col_addr       <= '0;
            matrix_element <= '0;
            valid_data_out <= 1'b0;
            frame_done     <= 1'b0;
            frame_error    <= 1'b0;
        end else begin
            valid_data_out <= 1'b0;
            frame_done     <= 1'b0;
            frame_error    <= 1'b0;
            case (state)
                IDLE: begin
                    if (crsdv && rxd == PREAMBLE_DIBIT) begin
                        pre_cnt <= PRE_ONE;
                        state   <= PREAMBLE;
                    end
                end
                PREAMBLE: begin
                    if (!crsdv) begin
                        state <= IDLE;
                    end else if (rxd == PREAMBLE_DIBIT) begin
                        if (pre_cnt < PRE_MIN) pre_cnt <= pre_cnt + PRE_ONE;
                    end else if (rxd == SFD_LAST_DIBIT && pre_cnt >= PRE_MIN) begin
                        row_cnt <= '0;
                        col_cnt <= '0;
                        state   <= PAYLOAD;
                    end else begin
                        state <= DRAIN;
                    end
                end
                PAYLOAD: begin
                    if (!crsdv) begin
                        frame_error <= 1'b1;
                        state       <= IDLE;
                    end else if (byte_tvalid) begin
                        valid_data_out <= 1'b1;
                        matrix_element <= byte_tdata;
                        row_addr       <= row_cnt;
                        col_addr       <= col_cnt;
                        if (col_cnt == LAST_COL) begin
                            col_cnt <= '0;
                            if (row_cnt == LAST_ROW) begin
                                frame_done <= 1'b1;
                                state      <= DRAIN;
                            end else begin
                                row_cnt <= row_cnt + ROW_ONE;
                            end
                        end else begin
                            col_cnt <= col_cnt + COL_ONE;
                        end
                    end
                end
                DRAIN: begin
                    if (!crsdv) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
